// File: rtl/account_session_ctrl_if.sv
// rtl/account_session_ctrl_if.sv - front-end/datapath/provisioning bus of the ATM session controller
interface account_session_ctrl_if #(
    parameter int CARD_W = 3,
    parameter int PSW_W  = 4,
    parameter int BAL_W  = 20
);
    logic              card_in;
    logic [CARD_W-1:0] card_number;
    logic              psw_valid;
    logic [PSW_W-1:0]  password_input;
    logic              op_done;
    logic [BAL_W-1:0]  updated_balance;
    logic              prov_we;
    logic [CARD_W-1:0] prov_card;
    logic [PSW_W-1:0]  prov_psw;
    logic [BAL_W-1:0]  prov_bal;
    logic [BAL_W-1:0]  balance;
    logic              auth_ok;
    logic              wrong_psw;
    logic              card_locked;
    logic              invalid_card;
    logic              session_timeout;

    modport master (
        output card_in, card_number, psw_valid, password_input, op_done, updated_balance,
               prov_we, prov_card, prov_psw, prov_bal,
        input  balance, auth_ok, wrong_psw, card_locked, invalid_card, session_timeout
    );

    modport slave (
        input  card_in, card_number, psw_valid, password_input, op_done, updated_balance,
               prov_we, prov_card, prov_psw, prov_bal,
        output balance, auth_ok, wrong_psw, card_locked, invalid_card, session_timeout
    );
endinterface

// File: rtl/account_session_ctrl.sv
// rtl/account_session_ctrl.sv - per-card ATM session FSM with PIN retry lockout; SESSION_TIMEOUT_EN adds inactivity eject
module account_session_ctrl #(
    parameter int CARD_W      = 3,
    parameter int PSW_W       = 4,
    parameter int BAL_W       = 20,
    parameter int USERS       = 7,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                  clk,
    input logic                  rst,
    account_session_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PIN, S_AUTH, S_EJECT} state_t;

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]     MAX_T   = TW'(MAX_TRIES);
    localparam logic [CARD_W:0]   USERS_L = (CARD_W + 1)'(USERS);

    state_t state_q, state_d;
    logic [CARD_W-1:0] cur_q, cur_d;
    logic [BAL_W-1:0]  balance_q, balance_d;
    logic auth_ok_q, auth_ok_d;
    logic wrong_psw_q, wrong_psw_d;
    logic card_locked_q, card_locked_d;
    logic invalid_card_q, invalid_card_d;

    logic [PSW_W-1:0] pin_q   [USERS];
    logic [BAL_W-1:0] bal_q   [USERS];
    logic [TW-1:0]    tries_q [USERS];
    logic             lock_q  [USERS];

    logic          card_valid, prov_valid;
    logic          prov_wr, bal_commit, tries_clr, tries_inc, lock_set;
    logic [TW-1:0] tries_cur, tries_next;
    logic          timer_hit;

    assign card_valid = {1'b0, bus.card_number} < USERS_L;
    assign prov_valid = {1'b0, bus.prov_card} < USERS_L;
    assign tries_cur  = tries_q[cur_q];
    assign tries_next = (tries_cur == MAX_T) ? MAX_T : tries_cur + 1'b1;

`ifdef SESSION_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYC - 1);

    logic [TMW-1:0] timer_q, timer_d;
    logic           session_timeout_q, session_timeout_d;

    assign timer_hit = (timer_q == TMO_LAST);

    // Any state change, keypad or datapath activity restarts the inactivity window.
    always_comb begin
        timer_d = '0;
        if ((state_q == S_PIN || state_q == S_AUTH) && state_d == state_q &&
            !bus.psw_valid && !bus.op_done) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q           <= '0;
            session_timeout_q <= 1'b0;
        end else begin
            timer_q           <= timer_d;
            session_timeout_q <= session_timeout_d;
        end
    end

    assign bus.session_timeout = session_timeout_q;
`else
    assign timer_hit           = 1'b0;
    assign bus.session_timeout = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        balance_d      = balance_q;
        auth_ok_d      = auth_ok_q;
        wrong_psw_d    = 1'b0;
        card_locked_d  = card_locked_q;
        invalid_card_d = invalid_card_q;
        prov_wr        = 1'b0;
        bal_commit     = 1'b0;
        tries_clr      = 1'b0;
        tries_inc      = 1'b0;
        lock_set       = 1'b0;
`ifdef SESSION_TIMEOUT_EN
        session_timeout_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.card_in) begin
                    cur_d = bus.card_number;
                    if (!card_valid) begin
                        invalid_card_d = 1'b1;
                        state_d        = S_EJECT;
                    end else if (lock_q[bus.card_number]) begin
                        card_locked_d = 1'b1;
                        state_d       = S_EJECT;
                    end else begin
                        state_d = S_PIN;
                    end
                end else if (bus.prov_we && prov_valid) begin
                    prov_wr = 1'b1;
                end
            end
            S_PIN: begin
                if (!bus.card_in) begin
                    state_d = S_IDLE;
                end else if (bus.psw_valid) begin
                    if (bus.password_input == pin_q[cur_q]) begin
                        tries_clr = 1'b1;
                        balance_d = bal_q[cur_q];
                        auth_ok_d = 1'b1;
                        state_d   = S_AUTH;
                    end else begin
                        wrong_psw_d = 1'b1;
                        tries_inc   = 1'b1;
                        if (tries_next == MAX_T) begin
                            lock_set      = 1'b1;
                            card_locked_d = 1'b1;
                            state_d       = S_EJECT;
                        end
                    end
                end else if (timer_hit) begin
`ifdef SESSION_TIMEOUT_EN
                    session_timeout_d = 1'b1;
`endif
                    state_d = S_EJECT;
                end
            end
            S_AUTH: begin
                // A commit coinciding with card removal still lands before leaving.
                if (bus.op_done) begin
                    bal_commit = 1'b1;
                    balance_d  = bus.updated_balance;
                end
                if (!bus.card_in) begin
                    state_d   = S_IDLE;
                    balance_d = '0;
                    auth_ok_d = 1'b0;
                end else if (!bus.op_done && timer_hit) begin
`ifdef SESSION_TIMEOUT_EN
                    session_timeout_d = 1'b1;
`endif
                    balance_d = '0;
                    auth_ok_d = 1'b0;
                    state_d   = S_EJECT;
                end
            end
            S_EJECT: begin
                if (!bus.card_in) begin
                    card_locked_d  = 1'b0;
                    invalid_card_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cur_q          <= '0;
            balance_q      <= '0;
            auth_ok_q      <= 1'b0;
            wrong_psw_q    <= 1'b0;
            card_locked_q  <= 1'b0;
            invalid_card_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            balance_q      <= balance_d;
            auth_ok_q      <= auth_ok_d;
            wrong_psw_q    <= wrong_psw_d;
            card_locked_q  <= card_locked_d;
            invalid_card_q <= invalid_card_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < USERS; i++) begin
                pin_q[i]   <= '0;
                bal_q[i]   <= '0;
                tries_q[i] <= '0;
                lock_q[i]  <= 1'b0;
            end
        end else begin
            if (prov_wr) begin
                pin_q[bus.prov_card]   <= bus.prov_psw;
                bal_q[bus.prov_card]   <= bus.prov_bal;
                tries_q[bus.prov_card] <= '0;
                lock_q[bus.prov_card]  <= 1'b0;
            end
            if (bal_commit) begin
                bal_q[cur_q] <= bus.updated_balance;
            end
            if (tries_clr) begin
                tries_q[cur_q] <= '0;
            end else if (tries_inc) begin
                tries_q[cur_q] <= tries_next;
            end
            if (lock_set) begin
                lock_q[cur_q] <= 1'b1;
            end
        end
    end

    assign bus.balance      = balance_q;
    assign bus.auth_ok      = auth_ok_q;
    assign bus.wrong_psw    = wrong_psw_q;
    assign bus.card_locked  = card_locked_q;
    assign bus.invalid_card = invalid_card_q;
endmodule
